ps2_kbd: RTL
============

# ps2_kbd

PS/2 keyboard responder on the CPU I/O space. It deserializes scan codes from the keyboard's PS/2 clock/data lines and buffers them in a small FIFO. It presents the head byte to the bus data mux as `ready`/`key_data`, and pops one entry each time the CPU completes an I/O read strobe (`io_rdn`). It is the device end of the keyboard read path: the bus decoder generates the strobe and this block answers it.

## Interface
Parameters:
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW entries.
- `TIMEOUT_CYCLES`, 25000: clk cycles without a PS/2 falling edge before a partial frame is abandoned. Must be < 65536.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock from pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data from pin; asynchronous.
- `io_rdn`  in  1  active-low I/O read strobe from the bus decoder.
- `ready`  out  1  FIFO non-empty; bit 31 of the read word.
- `key_data`  out  8  FIFO head byte; 0x00 when empty.
- `overflow`  out  1  sticky: a frame was dropped because the FIFO was full.

## Operation
- Synchronizer:
  - `ps2_clk` and `ps2_data` each pass through 2 flops.
  - A third `ps2_clk` history flop provides the edge reference.
  - A falling edge (`fe`) is detected when the history pair reads 1 then 0.
- Receive FSM, 2 states:
  - IDLE: on `fe` with sampled data = 0 (start bit), go to SHIFT with bitcnt = 1. On `fe` with data = 1, stay in IDLE.
  - SHIFT: on each `fe`, shift data into an 8-bit register LSB-first (bits 1..8), then capture parity (bit 9), then stop (bit 10). bitcnt increments on each `fe`.
  - After bit 10, return to IDLE and evaluate the frame. The frame is valid when stop = 1 and, when parity checking is enabled, the parity check passes.
  - A valid frame raises a 1-cycle `push`.
  - Timeout: a 16-bit counter runs in SHIFT and resets on each `fe`. When it reaches TIMEOUT_CYCLES the FSM returns to IDLE, the partial frame is discarded, and nothing is pushed.
- FIFO:
  - Write and read pointers are FIFO_AW+1 bits wide. The extra MSB distinguishes full from empty on wrap-around.
  - Storage is registers.
  - `key_data` = mem[rd_ptr] when non-empty, else 0x00.
- Pop:
  - A pop occurs on the `io_rdn` rising edge, i.e. the cycle where the prior-cycle `io_rdn` = 0 and the current `io_rdn` = 1, and only if the FIFO is non-empty.
  - The CPU samples `key_data` while the strobe is low, so the head byte stays stable for the entire low period.
  - A read while empty has no effect; the pointers do not move.
- Boundary cases:
  - Push while full: the frame is dropped, `overflow` is set, and the FIFO contents are unchanged.
  - Push and pop in the same cycle while full: the pop is applied first, so the push succeeds and `overflow` is not set.
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored.
  - `overflow` clears on the next successful pop or on `rst`.

## Timing
- Reset values: `ready` = 0, `key_data` = 0x00, `overflow` = 0. FSM = IDLE, pointers = 0, timeout counter = 0, synchronizer flops = 1.
- `rst` asserted mid-frame: the partial frame is lost and all state returns to reset on the next clk edge.
- Latency: `fe` is asserted 3 clk cycles after the pin's falling edge. `push` occurs on the cycle after the 11th `fe`. `ready` and `key_data` are valid on the cycle after `push`, i.e. 5 clk cycles after the 11th pin falling edge.
- Pop: `ready`/`key_data` update on the cycle after the `io_rdn` rising edge.
- `ready` is a registered output. `key_data` is mux-combinational from registered state only and is glitch-free relative to clk.

## Configuration
- `PS2_KBD_PARITY_CHK_EN` defined: the frame is valid only if the XOR of the 8 data bits and the parity bit = 1 (odd parity), in addition to stop = 1. Frames failing the check are silently dropped and do not touch `overflow`.
- `PS2_KBD_PARITY_CHK_EN` undefined: the parity bit is sampled but ignored, and the frame is valid when stop = 1.

## Test plan
- Single frame: send 0x1C with odd parity 0 and stop 1, PS/2 clk at 1/2000 of clk. Required: `ready` = 1 and `key_data` = 0x1C exactly 5 cycles after the 11th falling edge. Then pulse `io_rdn` low for 2 cycles; required: `ready` = 0 and `key_data` = 0x00 one cycle after the rising edge.
- Ordering and wrap: send 0x01..0x0C (12 frames) with FIFO_AW = 3, popping 4 entries after frame 6. Required: `key_data` sequence 0x01..0x0C with no loss, pointers wrapped, `overflow` = 0.
- Overflow: send 9 frames 0xA0..0xA8 with no reads. Required: `overflow` = 1 and the FIFO holds 0xA0..0xA7. One pop gives `key_data` = 0xA1 and `overflow` = 0.
- Parity: send 0x1C with parity bit 1. With the macro defined: `ready` stays 0. With the macro undefined: `ready` = 1 and `key_data` = 0x1C.
- Timeout: send start + 4 data bits, idle for TIMEOUT_CYCLES + 10, then send a full 0x5A frame. Required: only 0x5A is received.
- Reset mid-frame: assert `rst` for 1 cycle after bit 5 of 0x33, then send 0x76. Required: only 0x76 is received, and all outputs were at reset values in the cycle after `rst`.

Source files
------------

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: deserializes scan codes into a small FIFO read by the CPU via io_rdn.
// Latency: ready/key_data valid 5 clk after the 11th PS/2 clock falling edge; pop visible 1 clk after io_rdn rises.
// Backpressure: none toward the keyboard; a frame arriving while full is dropped and sets sticky overflow.
// Optional odd-parity check enabled by defining PS2_KBD_PARITY_CHK_EN.
module ps2_kbd #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       io_rdn,
    output logic       ready,
    output logic [7:0] key_data,
    output logic       overflow
);

    localparam int          DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

`ifdef PS2_KBD_PARITY_CHK_EN
    localparam logic PAR_CHK = 1'b1;
`else
    localparam logic PAR_CHK = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers; idle PS/2 lines are high, so flops reset to 1.
    // ------------------------------------------------------------------
    logic clk_s1, clk_s2, clk_s3;
    logic dat_s1, dat_s2;

    // Two-flop synchronizers plus one ps2_clk history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Falling-edge strobe and the data bit captured alongside it.
    logic fe;
    logic bit_dat;

    // Register the edge strobe so the FSM sees edge and data in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fe      <= 1'b0;
            bit_dat <= 1'b1;
        end else begin
            fe      <= clk_s3 & ~clk_s2;
            bit_dat <= dat_s2;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t      state;
    logic [3:0]  bitcnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic [15:0] to_cnt;
    logic        push;
    logic [7:0]  push_dat;
    logic        frame_ok;

    // Evaluated on the stop-bit edge: bit_dat is the stop bit at that point.
    always_comb begin
        frame_ok = bit_dat & (~PAR_CHK | (^{shreg, par_bit}));
    end

    // Frame deserializer with inactivity timeout; push is a 1-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bitcnt   <= 4'd0;
            shreg    <= 8'h00;
            par_bit  <= 1'b0;
            to_cnt   <= 16'd0;
            push     <= 1'b0;
            push_dat <= 8'h00;
        end else begin
            push <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_cnt <= 16'd0;
                    if (fe && !bit_dat) begin
                        state  <= ST_SHIFT;
                        bitcnt <= 4'd1;
                    end
                end
                ST_SHIFT: begin
                    if (fe) begin
                        to_cnt <= 16'd0;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt <= 4'd8) begin
                            shreg <= {bit_dat, shreg[7:1]};
                        end else if (bitcnt == 4'd9) begin
                            par_bit <= bit_dat;
                        end else begin
                            state    <= ST_IDLE;
                            bitcnt   <= 4'd0;
                            push     <= frame_ok;
                            push_dat <= shreg;
                        end
                    end else if (to_cnt >= TO_LIMIT) begin
                        // Keyboard went quiet mid-frame: abandon the partial byte.
                        state  <= ST_IDLE;
                        bitcnt <= 4'd0;
                        to_cnt <= 16'd0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    bitcnt <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO; the extra pointer MSB separates full from empty.
    // ------------------------------------------------------------------
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] wr_nxt, rd_nxt;
    logic [7:0]       mem [DEPTH];
    logic             rdn_q;
    logic             empty, full;
    logic             pop, wr_en, ovf_set;

    // Pop on the io_rdn rising edge so the head holds for the whole low period;
    // a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
        pop     = ~rdn_q & io_rdn & ~empty;
        wr_en   = push & (~full | pop);
        ovf_set = push & full & ~pop;
        wr_nxt  = wr_ptr + (FIFO_AW+1)'(wr_en);
        rd_nxt  = rd_ptr + (FIFO_AW+1)'(pop);
    end

    // Pointers, registered ready, strobe history and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready    <= 1'b0;
            rdn_q    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            ready  <= (wr_nxt != rd_nxt);
            rdn_q  <= io_rdn;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (pop) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= push_dat;
        end
    end

    // Head byte muxed from registered state only.
    always_comb begin
        key_data = ready ? mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;
    end

endmodule
